// File: rtl/tlb_pkg.sv
// Shared TLB constants: INVTLB op codes, page sizes, invalidate-engine state encoding.
// Optional feature macro used by tlb_inv_engine: INVTLB_FAST_ALL_EN.
package tlb_pkg;

    localparam int unsigned TLB_ENTRIES = 64;
    localparam int unsigned IDX_W       = 6;

    localparam logic [5:0] PS_4K   = 6'd12;
    localparam logic [5:0] PS_HUGE = 6'd21;

    localparam logic [4:0] INV_ALL0       = 5'd0;
    localparam logic [4:0] INV_ALL1       = 5'd1;
    localparam logic [4:0] INV_G          = 5'd2;
    localparam logic [4:0] INV_NG         = 5'd3;
    localparam logic [4:0] INV_NG_ASID    = 5'd4;
    localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GASID_VA   = 5'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DONE
    } inv_state_e;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= INV_GASID_VA;
    endfunction

endpackage

// File: rtl/invtlb_match.sv
// Combinational INVTLB entry matcher: op/ASID/VA/PS compare against one TLB entry.
// Shared between the invalidate walker and the TLBSRCH path.
module invtlb_match #(
    parameter logic [5:0] HUGE_PS = tlb_pkg::PS_HUGE
) (
    input  logic [4:0]  i_op,
    input  logic [9:0]  i_asid,
    input  logic [18:0] i_va,
    input  logic        i_ent_g,
    input  logic [9:0]  i_ent_asid,
    input  logic [18:0] i_ent_vpn,
    input  logic [5:0]  i_ent_ps,
    output logic        o_match
);
    import tlb_pkg::*;

    logic w_asid_eq;
    logic w_vam;

    always_comb begin
        w_asid_eq = (i_asid == i_ent_asid);
        // Huge pages only cover VA[31:22], i.e. bits [18:9] of the VA[31:13] operand
        if (i_ent_ps == HUGE_PS) begin
            w_vam = (i_va[18:9] == i_ent_vpn[18:9]);
        end else begin
            w_vam = (i_va == i_ent_vpn);
        end

        o_match = 1'b0;
        case (i_op)
            INV_ALL0, INV_ALL1: o_match = 1'b1;
            INV_G:              o_match = i_ent_g;
            INV_NG:             o_match = ~i_ent_g;
            INV_NG_ASID:        o_match = ~i_ent_g & w_asid_eq;
            INV_NG_ASID_VA:     o_match = ~i_ent_g & w_asid_eq & w_vam;
            INV_GASID_VA:       o_match = (i_ent_g | w_asid_eq) & w_vam;
            default:            o_match = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_inv_engine.sv
// INVTLB sequencer: walks every TLB entry, clears E on matches, reports done/illegal op.
// Optional macro INVTLB_FAST_ALL_EN adds flash_clr for a single-cycle op 0/1 flush.
module tlb_inv_engine #(
    parameter int unsigned TLB_ENTRIES = tlb_pkg::TLB_ENTRIES,
    parameter int unsigned IDX_W       = tlb_pkg::IDX_W,
    parameter logic [5:0]  PS_HUGE     = tlb_pkg::PS_HUGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv_valid,
    output logic             inv_ready,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_va,
    input  logic             tlb_wr_busy,
    output logic [IDX_W-1:0] rd_idx,
    input  logic             rd_e,
    input  logic             rd_g,
    input  logic [9:0]       rd_asid,
    input  logic [18:0]      rd_vpn,
    input  logic [5:0]       rd_ps,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx,
    output logic             done,
    output logic             op_illegal,
    output logic             busy
`ifdef INVTLB_FAST_ALL_EN
    ,
    output logic             flash_clr
`endif
);
    import tlb_pkg::*;

    inv_state_e       r_state;
    inv_state_e       w_next;
    logic [IDX_W-1:0] r_idx;
    logic [4:0]       r_op;
    logic [9:0]       r_asid;
    logic [18:0]      r_va;

    logic w_match;
    logic w_last;
    logic w_accept;
    logic w_clr;
    logic w_ready;
    logic w_flash;

    invtlb_match #(
        .HUGE_PS (PS_HUGE)
    ) u_match (
        .i_op       (r_op),
        .i_asid     (r_asid),
        .i_va       (r_va),
        .i_ent_g    (rd_g),
        .i_ent_asid (rd_asid),
        .i_ent_vpn  (rd_vpn),
        .i_ent_ps   (rd_ps),
        .o_match    (w_match)
    );

    assign w_last = (r_idx == IDX_W'(TLB_ENTRIES - 1));

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_accept   = 1'b0;
        w_clr      = 1'b0;
        w_flash    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        op_illegal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
`ifdef INVTLB_FAST_ALL_EN
                // Flash clear must not race a TLBWR/TLBFILL write, so op 0/1 waits here
                if (tlb_wr_busy && (inv_op <= INV_ALL1)) begin
                    w_ready = 1'b0;
                end
`endif
                w_accept = inv_valid & w_ready;
                if (w_accept) begin
                    if (!op_is_legal(inv_op)) begin
                        w_next = ST_DONE;
`ifdef INVTLB_FAST_ALL_EN
                    end else if (inv_op <= INV_ALL1) begin
                        w_flash = 1'b1;
                        w_next  = ST_DONE;
`endif
                    end else begin
                        w_next = ST_WALK;
                    end
                end
            end
            ST_WALK: begin
                busy = 1'b1;
                if (!tlb_wr_busy) begin
                    w_clr = rd_e & w_match;
                    if (w_last) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                op_illegal = ~op_is_legal(r_op);
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_op    <= '0;
            r_asid  <= '0;
            r_va    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= inv_op;
                r_asid <= inv_asid;
                r_va   <= inv_va;
                r_idx  <= '0;
            end else if ((r_state == ST_WALK) && !tlb_wr_busy && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign inv_ready = w_ready;
    assign rd_idx    = r_idx;
    assign clr_idx   = r_idx;
    // A clear issued in a reset cycle would land on the reset edge; suppress it
    assign clr_en    = w_clr & rst_n;
`ifdef INVTLB_FAST_ALL_EN
    assign flash_clr = w_flash;
`endif

endmodule
